// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: handshake-stage state encoding, per-boundary
// control bundles and their NOP bubble values.
package cpu_pipe_pkg;

  localparam int unsigned PIPE_CTRL_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic        pred_taken;
    logic        fetch_fault;
    logic [13:0] rsvd;
  } if_id_ctrl_t;

  typedef struct packed {
    logic [5:0] alu_op;
    logic [1:0] src_a_sel;
    logic [1:0] src_b_sel;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       branch;
    logic       jump;
    logic       rsvd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic [2:0] mem_size;
    logic [1:0] wb_sel;
    logic [7:0] rsvd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [12:0] rsvd;
  } mem_wb_ctrl_t;

  // All-zero control words carry no write enables, so they are safe bubbles.
  localparam if_id_ctrl_t  IF_ID_NOP  = '0;
  localparam id_ex_ctrl_t  ID_EX_NOP  = '0;
  localparam ex_mem_ctrl_t EX_MEM_NOP = '0;
  localparam mem_wb_ctrl_t MEM_WB_NOP = '0;

  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data+ctrl holding register; clear wins over load and returns the
// slot to the bubble value.
module pipe_skid_slot #(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_BUBBLE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register between two stages, with optional
// 2-entry skid buffer and a synchronous bubble-injecting flush.
module pipe_stage_elastic
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int unsigned        SKID        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  pipe_state_t       state, state_next;
  logic              in_ready_q;
  logic              in_xfer, out_xfer;
  logic              head_load, head_clear, skid_load, skid_clear;
  logic              head_valid, skid_valid;
  logic [DATA_W-1:0] skid_data, head_src_data;
  logic [CTRL_W-1:0] skid_ctrl, head_src_ctrl;

  assign in_ready  = (SKID != 0) ? in_ready_q : (out_ready | ~head_valid);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = head_valid & out_ready;
  assign out_valid = head_valid;
  assign occupancy = state_occupancy(state);

  // The skid slot is only ever valid in FULL, so it selects the refill source.
  assign head_src_data = skid_valid ? skid_data : in_data;
  assign head_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;

  always_comb begin
    state_next = state;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            head_load  = 1'b1;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            head_load = 1'b1;
          end else if (in_xfer) begin
            skid_load  = 1'b1;
            state_next = ST_FULL;
          end else if (out_xfer) begin
            head_clear = 1'b1;
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            head_load  = 1'b1;
            skid_clear = 1'b1;
            state_next = ST_ONE;
          end
        end
        default: begin
          head_clear = 1'b1;
          skid_clear = 1'b1;
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_FULL);
    end
  end

  pipe_skid_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_head (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (head_clear),
    .load      (head_load),
    .load_data (head_src_data),
    .load_ctrl (head_src_ctrl),
    .valid     (head_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  pipe_skid_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (skid_clear),
    .load      (skid_load),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

endmodule
